// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one APU-style FPU port among NB_CORES cores, with
// per-core in-flight limits, tag-based result routing and a drain/halt FSM.
module fpu_share_arbiter #(
  parameter  int NB_CORES        = 4,
  parameter  int ID_WIDTH        = 9,
  parameter  int NB_ARGS         = 3,
  parameter  int OPCODE_WIDTH    = 6,
  parameter  int DATA_WIDTH      = 32,
  parameter  int FLAGS_IN_WIDTH  = 15,
  parameter  int FLAGS_OUT_WIDTH = 5,
  parameter  int MAX_OUTST       = 2,
  localparam int IDX_W           = (NB_CORES > 1) ? $clog2(NB_CORES) : 1,
  localparam int TAG_W           = IDX_W + ID_WIDTH
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [NB_CORES-1:0]                                  core_req_i,
  output logic [NB_CORES-1:0]                                  core_gnt_o,
  input  logic [NB_CORES-1:0][ID_WIDTH-1:0]                    core_ID_i,
  input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0]     core_operands_i,
  input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]                core_op_i,
  input  logic [NB_CORES-1:0][FLAGS_IN_WIDTH-1:0]              core_flags_i,
  output logic [NB_CORES-1:0]                                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                                core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]                           core_rflags_o,
  output logic [ID_WIDTH-1:0]                                  core_rID_o,
  output logic                                                 fpu_req_o,
  input  logic                                                 fpu_gnt_i,
  output logic [TAG_W-1:0]                                     fpu_ID_o,
  output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]                   fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                              fpu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]                            fpu_flags_o,
  input  logic                                                 fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                                fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]                           fpu_rflags_i,
  input  logic [TAG_W-1:0]                                     fpu_rID_i,
  input  logic                                                 drain_i,
  output logic                                                 halted_o,
  output logic                                                 busy_o,
  output logic                                                 err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [CNT_W-1:0]           r_cnt [NB_CORES];
  logic [IDX_W-1:0]           r_rr;
  logic [1:0]                 r_state;
  logic                       r_halted;
  logic                       r_err;
  logic [NB_CORES-1:0]        r_rvalid;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic [FLAGS_OUT_WIDTH-1:0] r_rflags;
  logic [ID_WIDTH-1:0]        r_rid;

  logic [NB_CORES-1:0]        w_elig;
  logic [NB_CORES-1:0]        w_gnt;
  logic [NB_CORES-1:0]        w_hit;
  logic [NB_CORES-1:0]        w_dec;
  logic [IDX_W-1:0]           w_winner;
  logic [IDX_W-1:0]           w_rr_nxt;
  logic [IDX_W-1:0]           w_ridx;
  logic                       w_found;
  logic                       w_accept;
  logic                       w_busy;
  logic                       w_zero_hit;
  logic                       w_bad_idx;
  logic [1:0]                 w_state_nxt;

  // Drain request blocks eligibility in the very cycle it is raised.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NB_CORES; i++) begin
      w_elig[i] = core_req_i[i] && (r_cnt[i] < CNT_W'(MAX_OUTST)) &&
                  (r_state == S_RUN) && !drain_i;
      w_busy    = w_busy | (r_cnt[i] != '0);
    end
  end

  always_comb begin
    int j;
    j        = 0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NB_CORES; k++) begin
      j = int'(r_rr) + k;
      if (j >= NB_CORES) j = j - NB_CORES;
      if (!w_found && w_elig[j]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(j);
      end
    end
  end

  assign fpu_req_o = |w_elig;
  assign w_accept  = fpu_req_o & fpu_gnt_i;
  assign w_rr_nxt  = (int'(w_winner) == NB_CORES - 1) ? '0 : w_winner + IDX_W'(1);

  always_comb begin
    fpu_operands_o = core_operands_i[0];
    fpu_op_o       = core_op_i[0];
    fpu_flags_o    = core_flags_i[0];
    fpu_ID_o       = {IDX_W'(0), core_ID_i[0]};
    for (int i = 0; i < NB_CORES; i++) begin
      w_gnt[i] = w_accept && (w_winner == IDX_W'(i));
      if (w_winner == IDX_W'(i)) begin
        fpu_operands_o = core_operands_i[i];
        fpu_op_o       = core_op_i[i];
        fpu_flags_o    = core_flags_i[i];
        fpu_ID_o       = {IDX_W'(i), core_ID_i[i]};
      end
    end
  end

  assign core_gnt_o = w_gnt;
  assign w_ridx     = fpu_rID_i[TAG_W-1 -: IDX_W];

  // A tag index matching no core leaves w_hit empty, so the result is dropped.
  always_comb begin
    w_zero_hit = 1'b0;
    for (int i = 0; i < NB_CORES; i++) begin
      w_hit[i]   = fpu_rvalid_i && (w_ridx == IDX_W'(i));
      w_dec[i]   = w_hit[i] && (r_cnt[i] != '0);
      w_zero_hit = w_zero_hit | (w_hit[i] && (r_cnt[i] == '0));
    end
  end

  assign w_bad_idx = fpu_rvalid_i && (w_hit == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (drain_i) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (!drain_i) w_state_nxt = S_RUN;
                else if (!w_busy && !fpu_rvalid_i) w_state_nxt = S_HALTED;
      S_HALTED: if (!drain_i) w_state_nxt = S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr     <= '0;
      r_state  <= S_RUN;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rflags <= '0;
      r_rid    <= '0;
      for (int i = 0; i < NB_CORES; i++) r_cnt[i] <= '0;
    end else begin
      if (w_accept) r_rr <= w_rr_nxt;
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == S_HALTED);
      r_err    <= r_err | w_bad_idx | w_zero_hit;
      r_rvalid <= w_hit;
      if (|w_hit) begin
        r_rdata  <= fpu_rdata_i;
        r_rflags <= fpu_rflags_i;
        r_rid    <= fpu_rID_i[ID_WIDTH-1:0];
      end
      for (int i = 0; i < NB_CORES; i++) begin
        case ({w_gnt[i], w_dec[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  assign core_rvalid_o = r_rvalid;
  assign core_rdata_o  = r_rdata;
  assign core_rflags_o = r_rflags;
  assign core_rID_o    = r_rid;
  assign halted_o      = r_halted;
  assign busy_o        = w_busy;
  assign err_o         = r_err;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter: a 4-core instance for the main
// behaviour and a 3-core instance for out-of-range result tags.
module tb_fpu_share_arbiter;

  localparam int NC  = 4;
  localparam int IDW = 9;
  localparam int NA  = 3;
  localparam int OPW = 6;
  localparam int DW  = 32;
  localparam int FIW = 15;
  localparam int FOW = 5;
  localparam int MO  = 2;
  localparam int TW  = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]                 core_req, core_gnt, core_rvalid;
  logic [NC-1:0][IDW-1:0]        core_id;
  logic [NC-1:0][NA-1:0][DW-1:0] core_opnd;
  logic [NC-1:0][OPW-1:0]        core_op;
  logic [NC-1:0][FIW-1:0]        core_flags;
  logic [DW-1:0]                 core_rdata;
  logic [FOW-1:0]                core_rflags;
  logic [IDW-1:0]                core_rid;
  logic                          fpu_req, fpu_gnt, fpu_rvalid;
  logic [TW-1:0]                 fpu_id, fpu_rid;
  logic [NA-1:0][DW-1:0]         fpu_opnd;
  logic [OPW-1:0]                fpu_op;
  logic [FIW-1:0]                fpu_flags;
  logic [DW-1:0]                 fpu_rdata;
  logic [FOW-1:0]                fpu_rflags;
  logic                          drain, halted, busy, err;

  logic [2:0]                    u3_req, u3_gnt, u3_rvalid;
  logic [2:0][IDW-1:0]           u3_id;
  logic [2:0][NA-1:0][DW-1:0]    u3_opnd;
  logic [2:0][OPW-1:0]           u3_op;
  logic [2:0][FIW-1:0]           u3_flags;
  logic [DW-1:0]                 u3_rdata_o;
  logic [FOW-1:0]                u3_rflags_o;
  logic [IDW-1:0]                u3_rid_o;
  logic                          u3_fpu_req, u3_fpu_rvalid;
  logic [TW-1:0]                 u3_fpu_id, u3_fpu_rid;
  logic [NA-1:0][DW-1:0]         u3_fpu_opnd;
  logic [OPW-1:0]                u3_fpu_op;
  logic [FIW-1:0]                u3_fpu_flags;
  logic [DW-1:0]                 u3_fpu_rdata;
  logic                          u3_halted, u3_busy, u3_err;

  int checks = 0;
  int errors = 0;

  fpu_share_arbiter #(
    .NB_CORES(NC), .ID_WIDTH(IDW), .NB_ARGS(NA), .OPCODE_WIDTH(OPW), .DATA_WIDTH(DW),
    .FLAGS_IN_WIDTH(FIW), .FLAGS_OUT_WIDTH(FOW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_gnt_o(core_gnt), .core_ID_i(core_id),
    .core_operands_i(core_opnd), .core_op_i(core_op), .core_flags_i(core_flags),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_rflags_o(core_rflags),
    .core_rID_o(core_rid),
    .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt), .fpu_ID_o(fpu_id), .fpu_operands_o(fpu_opnd),
    .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags), .fpu_rvalid_i(fpu_rvalid),
    .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags), .fpu_rID_i(fpu_rid),
    .drain_i(drain), .halted_o(halted), .busy_o(busy), .err_o(err)
  );

  fpu_share_arbiter #(
    .NB_CORES(3), .ID_WIDTH(IDW), .NB_ARGS(NA), .OPCODE_WIDTH(OPW), .DATA_WIDTH(DW),
    .FLAGS_IN_WIDTH(FIW), .FLAGS_OUT_WIDTH(FOW), .MAX_OUTST(MO)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(u3_req), .core_gnt_o(u3_gnt), .core_ID_i(u3_id),
    .core_operands_i(u3_opnd), .core_op_i(u3_op), .core_flags_i(u3_flags),
    .core_rvalid_o(u3_rvalid), .core_rdata_o(u3_rdata_o), .core_rflags_o(u3_rflags_o),
    .core_rID_o(u3_rid_o),
    .fpu_req_o(u3_fpu_req), .fpu_gnt_i(1'b1), .fpu_ID_o(u3_fpu_id), .fpu_operands_o(u3_fpu_opnd),
    .fpu_op_o(u3_fpu_op), .fpu_flags_o(u3_fpu_flags), .fpu_rvalid_i(u3_fpu_rvalid),
    .fpu_rdata_i(u3_fpu_rdata), .fpu_rflags_i(5'h00), .fpu_rID_i(u3_fpu_rid),
    .drain_i(1'b0), .halted_o(u3_halted), .busy_o(u3_busy), .err_o(u3_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    core_req = '0; fpu_gnt = 1'b0; fpu_rvalid = 1'b0; fpu_rid = '0;
    fpu_rdata = '0; fpu_rflags = '0; drain = 1'b0;
    for (int i = 0; i < NC; i++) begin
      core_id[i]    = IDW'(9'h100 + i);
      core_opnd[i]  = {DW'(32'hA000_0000 + i), DW'(32'hB000_0000 + i), DW'(32'hC000_0000 + i)};
      core_op[i]    = OPW'(i + 1);
      core_flags[i] = FIW'(15'h0100 + i);
    end
    u3_req = '0; u3_id = '0; u3_opnd = '0; u3_op = '0; u3_flags = '0;
    u3_fpu_rvalid = 1'b0; u3_fpu_rid = '0; u3_fpu_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    mid();
    checks++; if (core_rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid got=%b exp=0000", core_rvalid); end
    checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", core_rdata); end
    checks++; if (core_rflags !== 5'h0) begin errors++; $display("FAIL rst_rflags got=%h exp=0", core_rflags); end
    checks++; if (core_rid !== 9'h0) begin errors++; $display("FAIL rst_rid got=%h exp=0", core_rid); end
    checks++; if ({halted, busy, err} !== 3'b000) begin errors++; $display("FAIL rst_status got=%b exp=000", {halted, busy, err}); end
    checks++; if ({fpu_req, core_gnt} !== 5'b0) begin errors++; $display("FAIL rst_req got=%b exp=00000", {fpu_req, core_gnt}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    core_req = 4'b0010; fpu_gnt = 1'b1;
    core_id[1] = 9'h055; core_op[1] = 6'h2A; core_flags[1] = 15'h1234;
    core_opnd[1] = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    mid();
    checks++; if (core_gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt0 got=%b exp=0010", core_gnt); end
    checks++; if (fpu_id !== {2'd1, 9'h055}) begin errors++; $display("FAIL single_tag got=%h exp=%h", fpu_id, {2'd1, 9'h055}); end
    checks++; if (fpu_opnd !== core_opnd[1] || fpu_op !== 6'h2A || fpu_flags !== 15'h1234) begin
      errors++; $display("FAIL single_payload got=%h/%h/%h", fpu_opnd, fpu_op, fpu_flags); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0 got=%b exp=0", busy); end
    step();
    mid();
    checks++; if (core_gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt1 got=%b exp=0010", core_gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got=%b exp=1", busy); end
    step();
    fpu_rvalid = 1'b1; fpu_rid = {2'd1, 9'h055}; fpu_rdata = 32'hCAFE_F00D; fpu_rflags = 5'h15;
    mid();
    checks++; if ({fpu_req, core_gnt} !== 5'b0) begin errors++; $display("FAIL single_stall got=%b exp=00000", {fpu_req, core_gnt}); end
    checks++; if (core_rvalid !== 4'b0000) begin errors++; $display("FAIL single_rv_early got=%b exp=0000", core_rvalid); end
    step();
    fpu_rdata = 32'hBEEF_0001; fpu_rflags = 5'h0A;
    mid();
    checks++; if (core_rvalid !== 4'b0010) begin errors++; $display("FAIL single_rv1 got=%b exp=0010", core_rvalid); end
    checks++; if (core_rdata !== 32'hCAFE_F00D || core_rflags !== 5'h15 || core_rid !== 9'h055) begin
      errors++; $display("FAIL single_rdata1 got=%h/%h/%h exp=cafef00d/15/055", core_rdata, core_rflags, core_rid); end
    checks++; if (core_gnt !== 4'b0010) begin errors++; $display("FAIL single_resume got=%b exp=0010", core_gnt); end
    step();
    fpu_rvalid = 1'b0; core_req = 4'b0000;
    mid();
    checks++; if (core_rvalid !== 4'b0010 || core_rdata !== 32'hBEEF_0001) begin
      errors++; $display("FAIL single_rv2 got=%b/%h exp=0010/beef0001", core_rvalid, core_rdata); end
    step();
    mid();
    checks++; if (core_rvalid !== 4'b0000 || core_rdata !== 32'hBEEF_0001) begin
      errors++; $display("FAIL single_hold got=%b/%h exp=0000/beef0001", core_rvalid, core_rdata); end
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL single_end got busy=%b err=%b exp 1/0", busy, err); end
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] exp_tag;
    do_reset();
    core_req = 4'b1111; fpu_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_tag = {2'(k % 4), IDW'(256 + (k % 4))};
      mid();
      checks++; if (core_gnt !== 4'(1 << (k % 4)) || fpu_id !== exp_tag) begin
        errors++; $display("FAIL rr_order k=%0d got=%b/%h exp=%b/%h", k, core_gnt, fpu_id, 4'(1 << (k % 4)), exp_tag); end
      step();
    end
    fpu_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      checks++; if (core_gnt !== 4'b0000 || fpu_req !== 1'b1 || fpu_id !== {2'd2, 9'h102}) begin
        errors++; $display("FAIL rr_hold k=%0d got=%b/%b/%h exp=0000/1/%h", k, core_gnt, fpu_req, fpu_id, {2'd2, 9'h102}); end
      step();
    end
    fpu_gnt = 1'b1;
    mid();
    checks++; if (core_gnt !== 4'b0100) begin errors++; $display("FAIL rr_after_hold got=%b exp=0100", core_gnt); end
    step();
    mid();
    checks++; if (core_gnt !== 4'b1000) begin errors++; $display("FAIL rr_next got=%b exp=1000", core_gnt); end
    step();
    mid();
    checks++; if ({fpu_req, core_gnt} !== 5'b0) begin errors++; $display("FAIL rr_limit got=%b exp=00000", {fpu_req, core_gnt}); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    core_req = 4'b0100; fpu_gnt = 1'b1; core_id[2] = 9'h0C3;
    mid();
    checks++; if (core_gnt !== 4'b0100) begin errors++; $display("FAIL same_gnt0 got=%b exp=0100", core_gnt); end
    step();
    fpu_rvalid = 1'b1; fpu_rid = {2'd2, 9'h0C3}; fpu_rdata = 32'h0000_5A5A;
    mid();
    checks++; if (core_gnt !== 4'b0100) begin errors++; $display("FAIL same_gnt1 got=%b exp=0100", core_gnt); end
    step();
    fpu_rvalid = 1'b0;
    mid();
    checks++; if (busy !== 1'b1 || core_rvalid !== 4'b0100) begin
      errors++; $display("FAIL same_busy got=%b/%b exp=1/0100", busy, core_rvalid); end
    checks++; if (core_gnt !== 4'b0100) begin errors++; $display("FAIL same_cnt_not2 got=%b exp=0100", core_gnt); end
    step();
    mid();
    checks++; if (core_gnt !== 4'b0000 || busy !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL same_cnt_is2 got=%b/%b/%b exp=0000/1/0", core_gnt, busy, err); end
  endtask

  task automatic test_drain();
    do_reset();
    core_req = 4'b0111; fpu_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      checks++; if (core_gnt !== 4'(1 << k)) begin errors++; $display("FAIL drain_issue k=%0d got=%b exp=%b", k, core_gnt, 4'(1 << k)); end
      step();
    end
    drain = 1'b1;
    mid();
    checks++; if ({fpu_req, core_gnt} !== 5'b0) begin errors++; $display("FAIL drain_block got=%b exp=00000", {fpu_req, core_gnt}); end
    step();
    for (int k = 0; k < 3; k++) begin
      fpu_rvalid = 1'b1; fpu_rid = {2'(k), IDW'(256 + k)}; fpu_rdata = DW'(k);
      mid();
      checks++; if (core_gnt !== 4'b0000 || halted !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL drain_wait k=%0d got=%b/%b/%b exp=0000/0/1", k, core_gnt, halted, busy); end
      step();
    end
    fpu_rvalid = 1'b0;
    mid();
    checks++; if (core_rvalid !== 4'b0100 || halted !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL drain_last got=%b/%b/%b exp=0100/0/0", core_rvalid, halted, busy); end
    step();
    mid();
    checks++; if (halted !== 1'b1 || core_gnt !== 4'b0000) begin
      errors++; $display("FAIL drain_halted got=%b/%b exp=1/0000", halted, core_gnt); end
    step();
    drain = 1'b0; core_req = 4'b1111;
    mid();
    checks++; if (halted !== 1'b1 || core_gnt !== 4'b0000) begin
      errors++; $display("FAIL drain_leave got=%b/%b exp=1/0000", halted, core_gnt); end
    step();
    mid();
    checks++; if (halted !== 1'b0 || core_gnt !== 4'b1000) begin
      errors++; $display("FAIL drain_resume got=%b/%b exp=0/1000", halted, core_gnt); end
  endtask

  task automatic test_errors();
    do_reset();
    fpu_rvalid = 1'b1; fpu_rid = {2'd3, 9'h1AB}; fpu_rdata = 32'hDEAD_BEEF; fpu_rflags = 5'h1F;
    u3_fpu_rvalid = 1'b1; u3_fpu_rid = {2'd3, 9'h1AB}; u3_fpu_rdata = 32'hDEAD_BEEF;
    mid();
    checks++; if (err !== 1'b0 || u3_err !== 1'b0) begin errors++; $display("FAIL err_pre got=%b/%b exp=0/0", err, u3_err); end
    step();
    fpu_rvalid = 1'b0; u3_fpu_rvalid = 1'b0;
    mid();
    checks++; if (core_rvalid !== 4'b1000 || core_rdata !== 32'hDEAD_BEEF || core_rid !== 9'h1AB) begin
      errors++; $display("FAIL err_zero_deliver got=%b/%h/%h exp=1000/deadbeef/1ab", core_rvalid, core_rdata, core_rid); end
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_zero_flag got=%b/%b exp=1/0", err, busy); end
    checks++; if (u3_rvalid !== 3'b000 || u3_err !== 1'b1 || u3_rdata_o !== 32'h0) begin
      errors++; $display("FAIL err_badidx got=%b/%b/%h exp=000/1/0", u3_rvalid, u3_err, u3_rdata_o); end
    step(); step(); step();
    mid();
    checks++; if (err !== 1'b1 || u3_err !== 1'b1 || core_rvalid !== 4'b0000) begin
      errors++; $display("FAIL err_sticky got=%b/%b/%b exp=1/1/0000", err, u3_err, core_rvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_req = 4'b1111; fpu_gnt = 1'b1;
    step(); step();
    fpu_rvalid = 1'b1; fpu_rid = {2'd3, 9'h0AA}; fpu_rdata = 32'h1234_5678; fpu_rflags = 5'h03;
    mid();
    checks++; if (core_gnt !== 4'b0100) begin errors++; $display("FAIL rstmid_pre_gnt got=%b exp=0100", core_gnt); end
    step();
    fpu_rvalid = 1'b0; rst_n = 1'b0;
    mid();
    checks++; if (err !== 1'b1 || core_rvalid !== 4'b1000) begin
      errors++; $display("FAIL rstmid_pre_state got=%b/%b exp=1/1000", err, core_rvalid); end
    step();
    rst_n = 1'b1;
    mid();
    checks++; if (core_rvalid !== 4'b0000 || core_rdata !== 32'h0 || core_rflags !== 5'h0 || core_rid !== 9'h0) begin
      errors++; $display("FAIL rstmid_outputs got=%b/%h/%h/%h exp=0", core_rvalid, core_rdata, core_rflags, core_rid); end
    checks++; if ({halted, busy, err} !== 3'b000) begin errors++; $display("FAIL rstmid_status got=%b exp=000", {halted, busy, err}); end
    checks++; if (core_gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first_gnt got=%b exp=0001", core_gnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_cycle();
    test_drain();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one APU-style FPU port, such as the fpnew wrapper, among NB_CORES requesting cores.
- Uses round-robin arbitration with a per-core outstanding-operation limit.
- Tags each issued operation with the core index and routes results back by tag.
- Has a drain FSM so the cluster controller can quiesce the FPU before power/clock gating or reconfiguration.

Parameters:
NB_CORES, 4, number of requesting cores (>=2)
ID_WIDTH, 9, per-core APU ID width
NB_ARGS, 3, operands per request
OPCODE_WIDTH, 6, APU opcode width
DATA_WIDTH, 32, operand/result width
FLAGS_IN_WIDTH, 15, request flags width
FLAGS_OUT_WIDTH, 5, result status width
MAX_OUTST, 2, max in-flight ops per core (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
core_req_i  in  NB_CORES  per-core request
core_gnt_o  out  NB_CORES  per-core grant (one-hot or zero)
core_ID_i  in  NB_CORES x ID_WIDTH  per-core request ID
core_operands_i  in  NB_CORES x NB_ARGS x DATA_WIDTH  operands
core_op_i  in  NB_CORES x OPCODE_WIDTH  opcode
core_flags_i  in  NB_CORES x FLAGS_IN_WIDTH  flags
core_rvalid_o  out  NB_CORES  per-core result valid (one-hot or zero)
core_rdata_o  out  DATA_WIDTH  result, broadcast
core_rflags_o  out  FLAGS_OUT_WIDTH  status, broadcast
core_rID_o  out  ID_WIDTH  returned core ID, broadcast
fpu_req_o  out  1  request to FPU
fpu_gnt_i  in  1  FPU accepts
fpu_ID_o  out  TAG_W  tag {core_idx, core_ID}
fpu_operands_o  out  NB_ARGS x DATA_WIDTH  muxed operands
fpu_op_o  out  OPCODE_WIDTH  muxed opcode
fpu_flags_o  out  FLAGS_IN_WIDTH  muxed flags
fpu_rvalid_i  in  1  FPU result valid (no backpressure)
fpu_rdata_i  in  DATA_WIDTH  result
fpu_rflags_i  in  FLAGS_OUT_WIDTH  status
fpu_rID_i  in  TAG_W  returned tag
drain_i  in  1  drain request
halted_o  out  1  drained, no grants, nothing in flight
busy_o  out  1  any op in flight
err_o  out  1  sticky protocol error

Behaviour:
- Localparams: IDX_W = max(1, clog2(NB_CORES)); TAG_W = IDX_W + ID_WIDTH. The tag index occupies the MSBs.
- All state is synchronous. On rst_n=0 at a clk edge:
  - rr_q=0, all counters=0, state=RUN, err=0.
  - core_rvalid_o=0, core_rdata_o=0, core_rflags_o=0, core_rID_o=0.
  - halted_o=0, busy_o=0.
  - Reset mid-operation discards all in-flight bookkeeping; the FPU shares the same reset.
- Eligibility: eligible[i] = core_req_i[i] & (cnt[i] < MAX_OUTST) & (state==RUN).
- Arbitration (combinational):
  - Winner = first eligible index scanning rr_q, rr_q+1, ... modulo NB_CORES.
  - fpu_req_o = |eligible. FPU payload = winner's fields; fpu_ID_o = {winner, core_ID_i[winner]}.
  - core_gnt_o[winner] = fpu_gnt_i & fpu_req_o; all other grants 0.
  - fpu_req_o must not depend on fpu_gnt_i.
- rr_q <= winner+1 (wrap to 0 past NB_CORES-1) only on an accepted handshake. Otherwise rr_q holds.
- Counters, width clog2(MAX_OUTST+1):
  - +1 on grant to core i.
  - -1 when fpu_rvalid_i arrives with tag index i.
  - Grant and response for the same core in the same cycle: counter unchanged.
- Response path (1-cycle registered latency):
  - On fpu_rvalid_i at cycle N: core_rvalid_o[idx]=1 at cycle N+1; rdata/rflags/rID (tag LSBs) registered.
  - core_rvalid_o returns to 0 the cycle after unless another result arrives.
  - Data outputs hold their last value when not valid.
- Errors (err_o sticky until reset):
  - Returned index >= NB_CORES: result dropped (no rvalid), err set.
  - Response to a core with cnt==0: result still delivered, counter stays 0, err set.
- busy_o = OR of (cnt != 0), combinational from registered counters.
- FSM (RUN, DRAIN, HALTED):
  - RUN: drain_i=1 -> DRAIN. Eligibility is blocked in the same cycle drain_i is high, so no grant occurs.
  - DRAIN: no grants; responses still delivered and counted down.
    - drain_i=0 -> RUN.
    - All cnt==0 and fpu_rvalid_i=0 -> HALTED.
  - HALTED: halted_o=1 (registered, asserted the cycle after entering); drain_i=0 -> RUN.
- Core requests are held stable by the cores until granted. Ungranted requests are not recorded.

Test Plan:
- Single core 1 requests continuously, FPU gnt=1, results return 2 cycles later: core_gnt_o=0010 each cycle until cnt=2, then stalls; each fpu_rvalid with tag {1,ID} gives core_rvalid_o=0010 one cycle later, rID=ID, and issue resumes.
- All 4 cores requesting, gnt=1, MAX_OUTST large: grant order 0,1,2,3,0...; hold fpu_gnt_i=0 for 3 cycles: rr_q unchanged and the same winner is presented.
- Same-cycle grant and response for core 2 at cnt=1: cnt stays 1; busy_o stays 1.
- drain_i=1 with 3 ops in flight: no further core_gnt_o; halted_o=1 the cycle after the last result; drain_i=0 -> grants resume from rr_q.
- Inject fpu_rvalid_i with tag index 3 while cnt[3]=0: core_rvalid_o=1000 still delivered, err_o=1 sticky. NB_CORES=3 with returned index 3: no rvalid, err_o=1.
- Assert rst_n=0 mid-burst for 1 cycle: all outputs 0, counters 0, state RUN; the first grant after reset goes to core 0.
